// File: rtl/init_sequencer.sv
// Power-up sequencer: releases N_STAGES units in order via start/done handshake,
// then raises sticky ready; per-stage timeout raises error. Embedded SVA: INIT_SEQ_SVA_EN.
module init_sequencer #(
  parameter int unsigned N_STAGES = 4,
  parameter int unsigned SETTLE   = 2,
  parameter int unsigned TIMEOUT  = 16,
  localparam int unsigned SW      = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [N_STAGES-1:0] done_i,
  input  logic                retry_i,
  output logic [N_STAGES-1:0] start_o,
  output logic [SW-1:0]       stage_o,
  output logic                ready,
  output logic                error
);

  localparam int unsigned SCW = $clog2(SETTLE + 1);
  localparam int unsigned TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_RUN    = 2'd1,
    ST_READY  = 2'd2,
    ST_FAIL   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [SW-1:0]       stage_q, stage_d;
  logic [SCW-1:0]      settle_q, settle_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [N_STAGES-1:0] start_q, start_d;
  logic                ready_q, ready_d;
  logic                error_q, error_d;
  logic                cur_done;

  assign cur_done = done_i[stage_q];

  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    settle_d = settle_q;
    timer_d  = timer_q;
    ready_d  = ready_q;
    error_d  = error_q;

    case (state_q)
      ST_SETTLE: begin
        settle_d = settle_q + 1'b1;
        if (settle_d == SCW'(SETTLE)) begin
          state_d = ST_RUN;
          stage_d = '0;
          timer_d = '0;
        end
      end
      ST_RUN: begin
        // done beats a coincident timeout
        if (cur_done) begin
          if (stage_q == SW'(N_STAGES - 1)) begin
            state_d = ST_READY;
            ready_d = 1'b1;
          end else begin
            stage_d = stage_q + 1'b1;
            timer_d = '0;
          end
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d = ST_FAIL;
          error_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_READY: ;
      ST_FAIL: begin
        if (retry_i) begin
          state_d  = ST_SETTLE;
          stage_d  = '0;
          settle_d = '0;
          timer_d  = '0;
          error_d  = 1'b0;
        end
      end
      default: begin
        state_d  = ST_SETTLE;
        stage_d  = '0;
        settle_d = '0;
        timer_d  = '0;
        ready_d  = 1'b0;
        error_d  = 1'b0;
      end
    endcase

    // start is registered, so it follows the next stage on the same edge
    start_d = '0;
    for (int unsigned i = 0; i < N_STAGES; i++) begin
      start_d[i] = (state_d == ST_RUN) && (stage_d == SW'(i));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_SETTLE;
      stage_q  <= '0;
      settle_q <= '0;
      timer_q  <= '0;
      start_q  <= '0;
      ready_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      settle_q <= settle_d;
      timer_q  <= timer_d;
      start_q  <= start_d;
      ready_q  <= ready_d;
      error_q  <= error_d;
    end
  end

  assign start_o = start_q;
  assign stage_o = stage_q;
  assign ready   = ready_q;
  assign error   = error_q;

`ifdef INIT_SEQ_SVA_EN
  a_start_onehot0: assert property (@(posedge clk) disable iff (!rstn) $onehot0(start_o));
  a_ready_error_excl: assert property (@(posedge clk) disable iff (!rstn) !(ready && error));
  a_ready_low_after_rst: assert property (@(posedge clk) disable iff (!rstn) !$past(rstn) |-> !ready);
  a_start_stable: assert property (@(posedge clk) disable iff (!rstn)
    (state_q == ST_RUN && !done_i[stage_o] && timer_q != TW'(TIMEOUT - 1)) |=> $stable(start_o));
  a_ready_sticky: assert property (@(posedge clk) disable iff (!rstn) ready |=> ready);
  c_ready: cover property (@(posedge clk) disable iff (!rstn) state_q == ST_READY);
  c_fail: cover property (@(posedge clk) disable iff (!rstn) state_q == ST_FAIL);
`endif

endmodule

// File: tb/tb_init_sequencer.sv
// Randomized self-checking bench for init_sequencer against a phase/edge-count model.
module tb_init_sequencer;
  localparam int N       = 4;
  localparam int SETTLE  = 2;
  localparam int TIMEOUT = 16;

  logic         clk = 1'b0;
  logic         rstn;
  logic [N-1:0] done_i;
  logic         retry_i;
  logic [N-1:0] start_o;
  logic [1:0]   stage_o;
  logic         ready;
  logic         error;

  int n_checks = 0;
  int n_errors = 0;

  // model: phase 0=settling 1=running 2=ready 3=failed
  int m_phase, m_edges, m_stage;

  always #5 clk = ~clk;

  init_sequencer #(.N_STAGES(N), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn), .done_i(done_i), .retry_i(retry_i),
    .start_o(start_o), .stage_o(stage_o), .ready(ready), .error(error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_edges = 0; m_stage = 0;
  endtask

  task automatic model_edge(input logic [N-1:0] d, input logic r);
    case (m_phase)
      0: begin
        m_edges++;
        if (m_edges == SETTLE) begin m_phase = 1; m_stage = 0; m_edges = 0; end
      end
      1: begin
        if (d[m_stage]) begin
          if (m_stage == N - 1) m_phase = 2;
          else begin m_stage++; m_edges = 0; end
        end else begin
          m_edges++;
          if (m_edges == TIMEOUT) m_phase = 3;
        end
      end
      3: if (r) begin m_phase = 0; m_edges = 0; m_stage = 0; end
      default: ;
    endcase
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_start"}, start_o, (m_phase == 1) ? (32'd1 << m_stage) : 32'd0);
    check({tag, "_stage"}, stage_o, m_stage);
    check({tag, "_ready"}, ready, m_phase == 2);
    check({tag, "_error"}, error, m_phase == 3);
  endtask

  task automatic cycle(input string tag);
    logic [N-1:0] d;
    logic r;
    d = done_i;
    r = retry_i;
    @(posedge clk);
    #1;
    if (rstn) model_edge(d, r);
    check_outputs(tag);
  endtask

  task automatic do_reset();
    rstn = 1'b0; done_i = '0; retry_i = 1'b0;
    #1;
    model_reset();
    check_outputs("reset");
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b1; done_i = '0; retry_i = 1'b0;
    model_reset();
    @(negedge clk);

    // all done high: start walks 1,2,4,8 then ready after edge SETTLE+N
    do_reset();
    done_i = '1;
    for (int k = 1; k <= 8; k++) begin
      cycle("t1");
      if (k >= 2 && k <= 5) check("t1_walk", start_o, 32'd1 << (k - 2));
      if (k == 5) check("t1_ready_early", ready, 1'b0);
      if (k == 6) check("t1_ready_edge6", ready, 1'b1);
    end

    // stage 2 hangs: error on its 16th sampling edge (edge 20)
    do_reset();
    done_i = 4'b1011;
    for (int k = 1; k <= 22; k++) begin
      cycle("t2");
      if (k == 19) check("t2_no_err_yet", error, 1'b0);
      if (k == 20) begin
        check("t2_err", error, 1'b1);
        check("t2_stage", stage_o, 2);
        check("t2_start0", start_o, 0);
      end
    end

    // retry from failure, full settle then ready
    retry_i = 1'b1;
    cycle("t3_retry");
    check("t3_err_clr", error, 1'b0);
    retry_i = 1'b0;
    done_i = '1;
    for (int k = 1; k <= 7; k++) begin
      cycle("t3");
      if (k == 5) check("t3_ready_early", ready, 1'b0);
      if (k == 6) check("t3_ready", ready, 1'b1);
    end

    // done arrives on the last allowed edge of stage 1
    do_reset();
    done_i = 4'b1101;
    for (int k = 1; k <= 19; k++) begin
      if (k == 19) done_i[1] = 1'b1;
      cycle("t4");
    end
    check("t4_no_err", error, 1'b0);
    check("t4_stage2", stage_o, 2);
    check("t4_start", start_o, 4'b0100);

    // async reset mid-stage 2, then full resequence
    do_reset();
    done_i = 4'b1011;
    for (int k = 1; k <= 8; k++) cycle("t5");
    @(posedge clk);
    #3;
    model_edge(4'b1011, 1'b0);
    rstn = 1'b0;
    #1;
    model_reset();
    check("t5_async_start", start_o, 0);
    check("t5_async_stage", stage_o, 0);
    check_outputs("t5_rst");
    @(negedge clk);
    rstn = 1'b1;
    done_i = '1;
    for (int k = 1; k <= 6; k++) cycle("t5_reseq");
    check("t5_ready", ready, 1'b1);

    // random: noisy non-current done bits, sparse current done, random retry
    do_reset();
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      done_i = N'($urandom);
      if (m_phase == 1) done_i[m_stage] = ($urandom_range(0, 9) == 0);
      retry_i = ($urandom_range(0, 7) == 0);
      cycle("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
